// File: rtl/turbo_out_formatter.sv
// turbo_out_formatter: packs turbo encoder xk1/zk1/xk2/zk2 into rate-1/3 words
// {d2,d1,d0}, reorders the 12 termination bits into 4 tail words and buffers
// the words in a show-ahead FIFO with a valid/ready handshake.
// Ports: clk, reset (async, active-low), in_valid/in_tail/xk1/zk1/xk2/zk2/in_ready
// (input side), out_valid/out_ready/out_d/out_last (output side), err (sticky).
// Option: TURBO_FMT_BLKLEN_EN adds blk_len[12:0], data words of the last block.
module turbo_out_formatter #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_tail,
  input  logic       xk1,
  input  logic       zk1,
  input  logic       xk2,
  input  logic       zk2,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_d,
  output logic       out_last,
  output logic       err
`ifdef TURBO_FMT_BLKLEN_EN
  ,
  output logic [12:0] blk_len
`endif
);

  typedef enum logic {S_DATA, S_TAIL} state_e;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e      state_q, state_d;
  logic [2:0]  tcnt_q, tcnt_d;
  logic        x0_q, x0_d;
  logic [1:0]  z_q, z_d;
  logic        xp0_q, xp0_d;
  logic [1:0]  zp_q, zp_d;
  logic        err_q, err_d;

  logic        acc;
  logic        push;
  logic [2:0]  push_w;
  logic        push_last;
  logic        pop;

  logic [3:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [3:0]  rd_word;

  // Room is judged on the registered count only, so a pop never frees a
  // slot for a push in the same cycle.
  assign in_ready  = reset & (cnt_q != FULL);
  assign acc       = in_valid & in_ready;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;
  assign rd_word   = mem_q[rd_q];
  assign out_d     = out_valid ? rd_word[2:0] : 3'b000;
  assign out_last  = out_valid & rd_word[3];
  assign err       = err_q;

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    x0_d      = x0_q;
    z_d       = z_q;
    xp0_d     = xp0_q;
    zp_d      = zp_q;
    err_d     = err_q;
    push      = 1'b0;
    push_w    = 3'b000;
    push_last = 1'b0;
    if (acc) begin
      unique case (1'b1)
        !in_tail: begin
          // A data cycle inside a tail aborts the partial tail.
          if (state_q == S_TAIL) err_d = 1'b1;
          state_d = S_DATA;
          tcnt_d  = 3'd0;
          push    = 1'b1;
          push_w  = {zk2, zk1, xk1};
        end
        in_tail && (state_q == S_DATA): begin
          x0_d    = xk1;
          z_d[0]  = zk1;
          tcnt_d  = 3'd1;
          state_d = S_TAIL;
        end
        in_tail && (state_q == S_TAIL): begin
          tcnt_d = tcnt_q + 3'd1;
          case (tcnt_q)
            3'd1: begin
              z_d[1] = zk1;
              push   = 1'b1;
              push_w = {xk1, z_q[0], x0_q};
            end
            3'd2: begin
              push   = 1'b1;
              push_w = {zk1, xk1, z_q[1]};
            end
            3'd3: begin
              xp0_d   = xk2;
              zp_d[0] = zk2;
            end
            3'd4: begin
              zp_d[1] = zk2;
              push    = 1'b1;
              push_w  = {xk2, zp_q[0], xp0_q};
            end
            default: begin
              push      = 1'b1;
              push_w    = {zk2, xk2, zp_q[1]};
              push_last = 1'b1;
              tcnt_d    = 3'd0;
              state_d   = S_DATA;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_DATA;
      tcnt_q  <= 3'd0;
      x0_q    <= 1'b0;
      z_q     <= 2'b00;
      xp0_q   <= 1'b0;
      zp_q    <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      x0_q    <= x0_d;
      z_q     <= z_d;
      xp0_q   <= xp0_d;
      zp_q    <= zp_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'h0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {push_last, push_w};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef TURBO_FMT_BLKLEN_EN
  logic [12:0] dcnt_q, len_q;
  logic        dat_push;

  assign dat_push = acc & ~in_tail;
  assign blk_len  = len_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt_q <= '0;
      len_q  <= '0;
    end else if (push_last) begin
      len_q  <= dcnt_q;
      dcnt_q <= '0;
    end else if (dat_push && (dcnt_q != 13'h1FFF)) begin
      dcnt_q <= dcnt_q + 13'd1;
    end
  end
`else
  // No block-length counter in this build.
`endif

endmodule

// File: tb/tb_turbo_out_formatter.sv
// tb_turbo_out_formatter: directed bench for turbo_out_formatter.
// Drives inputs 1 ns after the rising edge and checks outputs there.
module tb_turbo_out_formatter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_tail = 1'b0;
  logic       xk1 = 1'b0;
  logic       zk1 = 1'b0;
  logic       xk2 = 1'b0;
  logic       zk2 = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_d;
  logic       out_last;
  logic       err;

  int errs = 0;
  int checks = 0;
  int acc;

  always #5 clk = ~clk;

  turbo_out_formatter #(.DEPTH(8), .AW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_tail   (in_tail),
    .xk1       (xk1),
    .zk1       (zk1),
    .xk2       (xk2),
    .zk2       (zk2),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d),
    .out_last  (out_last),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dat(input logic x, input logic z1, input logic z2);
    in_valid = 1'b1; in_tail = 1'b0;
    xk1 = x; zk1 = z1; xk2 = 1'b0; zk2 = z2;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic tl(input logic a, input logic b, input logic c,
                    input logic d);
    in_valid = 1'b1; in_tail = 1'b1;
    xk1 = a; zk1 = b; xk2 = c; zk2 = d;
    tick();
    in_valid = 1'b0; in_tail = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [2:0] d,
                     input logic l);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_d"}, out_d, d);
    chk({tag, "_last"}, out_last, l);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // x/z t0..2 = (1,0),(0,1),(1,1); x'/z' t3..5 = (0,1),(1,0),(1,1).
  // Unused bits are driven to 1 to catch wrong source selection.
  task automatic tail_std();
    tl(1, 0, 1, 1);
    tl(0, 1, 1, 1);
    tl(1, 1, 1, 1);
    in_valid = 1'b0;
    tick();
    tl(1, 1, 0, 1);
    tl(1, 1, 1, 0);
    tl(1, 1, 1, 1);
  endtask

  // {x1,z0,x0}=001, {z2,x2,z1}=111, {x'1,z'0,x'0}=110, {z'2,x'2,z'1}=110
  task automatic pop_tail(input string tag);
    pop({tag, "_t1"}, 3'b001, 1'b0);
    pop({tag, "_t2"}, 3'b111, 1'b0);
    pop({tag, "_t3"}, 3'b110, 1'b0);
    pop({tag, "_t4"}, 3'b110, 1'b1);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_d", out_d, 3'd0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    tick();

    // data words
    dat(1, 0, 1);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_d", out_d, 3'd5);
    dat(0, 1, 1);
    dat(1, 1, 0);
    pop("d0", 3'd5, 1'b0);
    pop("d1", 3'd6, 1'b0);
    pop("d2", 3'd3, 1'b0);
    chk("d_empty", out_valid, 1'b0);

    // empty block: tail only
    tl(1, 0, 1, 1);
    chk("t0_nopush", out_valid, 1'b0);
    tl(0, 1, 1, 1);
    tl(1, 1, 1, 1);
    in_valid = 1'b0;
    tick();
    tl(1, 1, 0, 1);
    tl(1, 1, 1, 0);
    tl(1, 1, 1, 1);
    pop_tail("tA");
    chk("tA_err", err, 1'b0);
    chk("tA_empty", out_valid, 1'b0);

    // fill with out_ready=0
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_tail = 1'b0;
      xk1 = i[0]; zk1 = i[1]; zk2 = i[2]; xk2 = 1'b0;
      if (in_ready) acc++;
      tick();
    end
    chk("fill_acc", acc[7:0], 8'd8);
    chk("fill_rdy", in_ready, 1'b0);
    chk("fill_head", out_d, 3'd0);
    // full, push and pop requested together: pop only
    xk1 = 1'b1; zk1 = 1'b0; zk2 = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("sim_rdy", in_ready, 1'b1);
    chk("sim_head", out_d, 3'd1);
    tick();
    in_valid = 1'b0;
    chk("sim_full", in_ready, 1'b0);
    for (int i = 1; i < 8; i++) pop("fifo", 3'(i), 1'b0);
    pop("fifo_w9", 3'd5, 1'b0);
    chk("fifo_empty", out_valid, 1'b0);

    // broken tail: t0,t1 then data
    tl(0, 0, 0, 0);
    tl(1, 0, 0, 0);
    dat(0, 1, 1);
    chk("err_set", err, 1'b1);
    dat(1, 1, 1);
    tail_std();
    chk("err_sticky", err, 1'b1);
    pop("e_t1", 3'b100, 1'b0);
    pop("e_dat", 3'd6, 1'b0);
    pop("e_dat2", 3'd7, 1'b0);
    pop_tail("tB");
    chk("e_empty", out_valid, 1'b0);

    // reset mid-tail with 5 words queued
    dat(1, 0, 1);
    dat(0, 1, 1);
    dat(1, 1, 0);
    tl(1, 0, 1, 1);
    tl(0, 1, 1, 1);
    tl(1, 1, 1, 1);
    reset = 1'b0;
    #1;
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_rdy", in_ready, 1'b0);
    chk("mr_err", err, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    tick();
    chk("mr_empty", out_valid, 1'b0);
    dat(1, 0, 1);
    tail_std();
    pop("mr_dat", 3'd5, 1'b0);
    pop_tail("tC");
    chk("mr_end", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
